// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and LSU results onto the integer register file's single
// write port (W1). ALU results take a free slot directly; LSU results are queued in
// a small circular FIFO and fill slots the ALU leaves idle. A full FIFO wins the slot
// and back-pressures both sources.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   alu_valid_i/alu_ready_o           ALU result handshake
//   alu_waddr_i/alu_wdata_i           ALU destination register and result
//   lsu_valid_i/lsu_ready_o           LSU result handshake
//   lsu_waddr_i/lsu_wdata_i           LSU destination register and load data
//   waddr_a_o/wdata_a_o/we_a_o        registered register-file write port
//   fifo_count_o                      current LSU FIFO occupancy
module wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid_i,
    output logic                          alu_ready_o,
    input  logic [ADDR_WIDTH-1:0]         alu_waddr_i,
    input  logic [DATA_WIDTH-1:0]         alu_wdata_i,
    input  logic                          lsu_valid_i,
    output logic                          lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0]         lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]         lsu_wdata_i,
    output logic [ADDR_WIDTH-1:0]         waddr_a_o,
    output logic [DATA_WIDTH-1:0]         wdata_a_o,
    output logic                          we_a_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    // FIFO storage and bookkeeping
    logic [ADDR_WIDTH-1:0] addr_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    // Registered write port
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  full;
    logic                  alu_fire;
    logic                  push;
    logic                  pop;
    logic                  slot_valid;
    logic [ADDR_WIDTH-1:0] slot_addr;
    logic [DATA_WIDTH-1:0] slot_data;

    // Readys depend on the registered count only, never on a valid input.
    assign full        = (count_q == FullCnt);
    assign alu_ready_o = !full;
    assign lsu_ready_o = !full;

    always_comb begin
        alu_fire = alu_valid_i && !full;
        push     = lsu_valid_i && !full;
        // Full FIFO takes the slot; otherwise the ALU has priority over queued entries.
        pop      = full || (!alu_fire && (count_q != '0));

        slot_valid = alu_fire || pop;
        if (pop) begin
            // Head comes from registered storage only: no same-cycle bypass of a push.
            slot_addr = addr_mem_q[rd_ptr_q];
            slot_data = data_mem_q[rd_ptr_q];
        end else begin
            slot_addr = alu_waddr_i;
            slot_data = alu_wdata_i;
        end

        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);

        // Idle slot keeps address and data; a write to x0 consumes the slot silently.
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (slot_valid) begin
            if (slot_addr == '0) begin
                waddr_d = '0;
                wdata_d = '0;
            end else begin
                we_d    = 1'b1;
                waddr_d = slot_addr;
                wdata_d = slot_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_mem_q[wr_ptr_q] <= lsu_waddr_i;
            data_mem_q[wr_ptr_q] <= lsu_wdata_i;
        end
    end

    assign we_a_o       = we_q;
    assign waddr_a_o    = waddr_q;
    assign wdata_a_o    = wdata_q;
    assign fifo_count_o = count_q;

endmodule
